// File: rtl/morse_pkg.sv
// Shared types and constants for the Morse decoder: FSM states and symbol codes.
package morse_pkg;

  localparam int CODE_W = 5;

  localparam logic [CODE_W-1:0] CODE_SPACE = 5'd26;
  localparam logic [CODE_W-1:0] CODE_ERR   = 5'd31;

  typedef enum logic [1:0] {
    IDLE,
    PRESS,
    GAP,
    WAIT_WORD
  } state_e;

endpackage

// File: rtl/morse_lut.sv
// Combinational ITU Morse lookup: element pattern (bit 0 = first, 1 = dash) to A-Z code.
module morse_lut
  import morse_pkg::*;
(
  input  logic [2:0]        len_i,
  input  logic [3:0]        pattern_i,
  input  logic              overflow_i,
  output logic [CODE_W-1:0] code_o
);

  // Any length/pattern pair not listed falls through to the error code.
  always_comb begin
    code_o = CODE_ERR;
    if (!overflow_i) begin
      case (len_i)
        3'd1: code_o = pattern_i[0] ? 5'd19 : 5'd4;
        3'd2: begin
          case (pattern_i[1:0])
            2'b00:   code_o = 5'd8;
            2'b10:   code_o = 5'd0;
            2'b01:   code_o = 5'd13;
            default: code_o = 5'd12;
          endcase
        end
        3'd3: begin
          case (pattern_i[2:0])
            3'b000:  code_o = 5'd18;
            3'b100:  code_o = 5'd20;
            3'b010:  code_o = 5'd17;
            3'b110:  code_o = 5'd22;
            3'b001:  code_o = 5'd3;
            3'b101:  code_o = 5'd10;
            3'b011:  code_o = 5'd6;
            default: code_o = 5'd14;
          endcase
        end
        3'd4: begin
          case (pattern_i)
            4'b0000: code_o = 5'd7;
            4'b1000: code_o = 5'd21;
            4'b0100: code_o = 5'd5;
            4'b0010: code_o = 5'd11;
            4'b0110: code_o = 5'd15;
            4'b1110: code_o = 5'd9;
            4'b0001: code_o = 5'd1;
            4'b1001: code_o = 5'd23;
            4'b0101: code_o = 5'd2;
            4'b1101: code_o = 5'd24;
            4'b0011: code_o = 5'd25;
            4'b1011: code_o = 5'd16;
            default: code_o = CODE_ERR;
          endcase
        end
        default: code_o = CODE_ERR;
      endcase
    end
  end

endmodule

// File: rtl/morse_decoder.sv
// Morse key decoder: times presses and gaps in ticks, emits letter codes and
// spaces with a one-cycle strobe for the scrolling display buffer.
module morse_decoder
  import morse_pkg::*;
#(
  parameter int DOT_TICKS  = 3,
  parameter int LETTER_GAP = 3,
  parameter int WORD_GAP   = 7
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tick,
  input  logic              key,
  output logic [CODE_W-1:0] letter,
  output logic              ex
);

  localparam int CNT_W = $clog2(WORD_GAP + 1);
  localparam logic [CNT_W-1:0] LETTER_MAX = CNT_W'(LETTER_GAP);
  localparam logic [CNT_W-1:0] WORD_MAX   = CNT_W'(WORD_GAP);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [3:0]        pattern_q, pattern_d;
  logic [2:0]        len_q, len_d;
  logic              ovf_q, ovf_d;
  logic [CODE_W-1:0] letter_q, letter_d;
  logic              ex_q, ex_d;

  logic [CNT_W-1:0]  cntInc;
  logic [CNT_W-1:0]  cntStep;
  logic              isDash;
  logic              letterEnd;
  logic              wordEnd;
  logic [CODE_W-1:0] lutCode;

  morse_lut u_lut (
    .len_i      (len_q),
    .pattern_i  (pattern_q),
    .overflow_i (ovf_q),
    .code_o     (lutCode)
  );

  // Counter saturates at WORD_GAP so a long hold or gap never wraps.
  assign cntInc    = (cnt_q == WORD_MAX) ? cnt_q : cnt_q + 1'b1;
  assign cntStep   = tick ? cntInc : cnt_q;
  assign isDash    = int'(cnt_q) >= DOT_TICKS;
  assign letterEnd = (state_q == GAP) && !key && tick && (cntInc == LETTER_MAX);
  assign wordEnd   = (state_q == WAIT_WORD) && !key && tick && (cntInc == WORD_MAX);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      pattern_q <= '0;
      len_q     <= '0;
      ovf_q     <= 1'b0;
      letter_q  <= CODE_SPACE;
      ex_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pattern_q <= pattern_d;
      len_q     <= len_d;
      ovf_q     <= ovf_d;
      letter_q  <= letter_d;
      ex_q      <= ex_d;
    end
  end

  // A key rise always wins over gap expiry in the same cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (key) state_d = PRESS;
      PRESS:     if (!key) state_d = GAP;
      GAP: begin
        if (key)            state_d = PRESS;
        else if (letterEnd) state_d = WAIT_WORD;
      end
      WAIT_WORD: begin
        if (key)          state_d = PRESS;
        else if (wordEnd) state_d = IDLE;
      end
      default:   state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d     = cnt_q;
    pattern_d = pattern_q;
    len_d     = len_q;
    ovf_d     = ovf_q;
    letter_d  = letter_q;
    ex_d      = 1'b0;
    case (state_q)
      IDLE: if (key) cnt_d = '0;
      PRESS: begin
        if (!key) begin
          cnt_d = '0;
          if (len_q == 3'd4) begin
            ovf_d = 1'b1;
          end else begin
            pattern_d[len_q[1:0]] = isDash;
            len_d = len_q + 3'd1;
          end
        end else begin
          cnt_d = cntStep;
        end
      end
      GAP: begin
        if (key) begin
          cnt_d = '0;
        end else begin
          cnt_d = cntStep;
          if (letterEnd) begin
            letter_d  = lutCode;
            ex_d      = 1'b1;
            pattern_d = '0;
            len_d     = '0;
            ovf_d     = 1'b0;
          end
        end
      end
      WAIT_WORD: begin
        if (key) begin
          cnt_d = '0;
        end else begin
          cnt_d = cntStep;
          if (wordEnd) begin
            letter_d = CODE_SPACE;
            ex_d     = 1'b1;
          end
        end
      end
      default: cnt_d = '0;
    endcase
  end

  assign letter = letter_q;
  assign ex     = ex_q;

endmodule

// File: tb/tb_morse_decoder.sv
// Directed bench for morse_decoder: keys letters with tick=1 and checks strobed codes.
module tb_morse_decoder;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       tick = 1'b1;
  logic       key = 1'b0;
  logic [4:0] letter;
  logic       ex;

  int passCount = 0;
  int checkCount = 0;
  int got[$];
  logic exPrev = 1'b0;

  morse_decoder dut (
    .clk    (clk),
    .reset  (reset),
    .tick   (tick),
    .key    (key),
    .letter (letter),
    .ex     (ex)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checkCount++;
    if (observed == expected) passCount++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
  endtask

  // Hold key at the given level for n clock edges; returns 1 time unit after the last edge.
  task automatic applyStimulus(input logic k, input int n);
    for (int i = 0; i < n; i++) begin
      key = k;
      @(posedge clk);
      #1;
    end
  endtask

  // Key one letter: bit i of pat is element i (1 = dash), one gap tick between elements.
  task automatic sendLetter(input int n, input logic [4:0] pat);
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'b1, pat[i] ? 5 : 1);
      if (i < n - 1) applyStimulus(1'b0, 2);
    end
    applyStimulus(1'b0, 5);
  endtask

  task automatic checkStrobes(input string tag, input int n, input int v0, input int v1);
    checkOutput({tag, "_count"}, got.size(), n);
    if (n > 0 && got.size() > 0) checkOutput({tag, "_0"}, got[0], v0);
    if (n > 1 && got.size() > 1) checkOutput({tag, "_1"}, got[1], v1);
    got.delete();
  endtask

  always @(negedge clk) begin
    if (ex) begin
      got.push_back(int'(letter));
      checkOutput("ex_single_cycle", int'(exPrev), 0);
    end
    exPrev = ex;
  end

  initial begin
    #1 reset = 1'b1;
    #2;
    checkOutput("reset_letter", int'(letter), 26);
    checkOutput("reset_ex", int'(ex), 0);
    applyStimulus(1'b0, 2);
    reset = 1'b0;
    applyStimulus(1'b0, 3);
    checkOutput("idle_ex", int'(ex), 0);

    // E then space, with exact strobe timing
    applyStimulus(1'b1, 1);
    applyStimulus(1'b0, 3);
    checkOutput("e_early", int'(ex), 0);
    applyStimulus(1'b0, 1);
    checkOutput("e_ex", int'(ex), 1);
    checkOutput("e_letter", int'(letter), 4);
    applyStimulus(1'b0, 1);
    checkOutput("e_ex_drop", int'(ex), 0);
    applyStimulus(1'b0, 2);
    checkOutput("space_early", int'(ex), 0);
    applyStimulus(1'b0, 1);
    checkOutput("space_ex", int'(ex), 1);
    checkOutput("space_letter", int'(letter), 26);
    applyStimulus(1'b0, 10);
    checkStrobes("e_space", 2, 4, 26);

    sendLetter(2, 5'b00010);
    checkStrobes("a", 1, 0, 0);
    sendLetter(4, 5'b00100);
    checkStrobes("f", 1, 5, 0);
    sendLetter(4, 5'b00011);
    checkStrobes("z", 1, 25, 0);
    sendLetter(5, 5'b00000);
    checkStrobes("overflow", 1, 31, 0);
    sendLetter(1, 5'b00000);
    checkStrobes("e_after_ovf", 1, 4, 0);
    sendLetter(4, 5'b01111);
    checkStrobes("dash4_err", 1, 31, 0);

    // Re-press on the cycle the gap would expire merges dot+dot into I
    applyStimulus(1'b1, 1);
    applyStimulus(1'b0, 3);
    applyStimulus(1'b1, 1);
    applyStimulus(1'b0, 5);
    checkStrobes("merge_i", 1, 8, 0);

    // No ticks while pressed: stays a dot
    tick = 1'b0;
    applyStimulus(1'b1, 20);
    applyStimulus(1'b0, 1);
    tick = 1'b1;
    applyStimulus(1'b0, 5);
    checkStrobes("notick_press", 1, 4, 0);

    // No ticks through the gap: never strobes
    tick = 1'b0;
    applyStimulus(1'b1, 1);
    applyStimulus(1'b0, 20);
    checkStrobes("notick_gap", 0, 0, 0);
    tick = 1'b1;
    applyStimulus(1'b0, 5);
    checkStrobes("notick_resume", 1, 4, 0);

    // Reset in the middle of a dash
    applyStimulus(1'b1, 3);
    #2 reset = 1'b1;
    #1;
    checkOutput("rst_dash_ex", int'(ex), 0);
    checkOutput("rst_dash_letter", int'(letter), 26);
    applyStimulus(1'b0, 2);
    reset = 1'b0;
    applyStimulus(1'b0, 2);
    sendLetter(1, 5'b00001);
    checkStrobes("t_after_rst", 1, 19, 0);

    // Reset during the strobe cycle drops ex asynchronously
    applyStimulus(1'b1, 1);
    applyStimulus(1'b0, 4);
    checkOutput("pre_rst_ex", int'(ex), 1);
    #2 reset = 1'b1;
    #1;
    checkOutput("rst_strobe_ex", int'(ex), 0);
    applyStimulus(1'b0, 1);
    reset = 1'b0;
    applyStimulus(1'b0, 12);
    checkStrobes("rst_strobe", 0, 0, 0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/morse_decoder.md
# morse_decoder

Converts a single debounced Morse key into a stream of 5-bit symbol codes with a one-cycle strobe. Classifies each press as dot or dash by duration, ends a letter after a silent gap and emits a space after a longer gap. Sits directly upstream of the 7-segment scrolling display buffer: `letter`/`ex` drive that buffer's `in`/`ex` inputs unchanged.

## Interface

- `DOT_TICKS`, default 3: presses shorter than this many ticks are dots; all others are dashes.
- `LETTER_GAP`, default 3: release length in ticks that ends a letter.
- `WORD_GAP`, default 7: release length in ticks, counted from the same release, that emits a space. Must be greater than `LETTER_GAP`.

- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `tick`  in  1  one-cycle time-base enable; all durations are counted in ticks.
- `key`  in  1  Morse key level, high while pressed; already debounced and synchronous to `clk`.
- `letter`  out  5  symbol code; held between strobes.
- `ex`  out  1  one-cycle strobe; `letter` is valid in the same cycle.

## Operation

- Symbol codes: 0–25 = A–Z, 26 = SPACE, 31 = ERROR; 27–30 are never produced.
- Element store: pattern[3:0] and len[2:0] (0–4), plus an overflow flag.
  - Element i is held in bit i; the first element is bit 0.
  - 0 = dot, 1 = dash.
- Counter `cnt` has width $clog2(WORD_GAP+1) and saturates at WORD_GAP.

FSM states: IDLE, PRESS, GAP, WAIT_WORD.

- **IDLE**: `key`=1 → PRESS with `cnt`=0.
- **PRESS**:
  - `cnt` increments on each `tick` cycle.
  - On the cycle `key`=0, classify using the pre-increment `cnt`: dot if `cnt` < DOT_TICKS, else dash.
  - Append the element at index len. If len was already 4, set overflow instead and leave the pattern unchanged.
  - Then → GAP with `cnt`=0.
- **GAP**:
  - `key`=1 → PRESS with `cnt`=0. Key rise takes priority over gap expiry in the same cycle.
  - Otherwise `cnt` increments on `tick`. When the incremented value equals LETTER_GAP: register the looked-up code into `letter`, assert `ex` next cycle, clear pattern/len/overflow, and go to WAIT_WORD. `cnt` is not cleared.
- **WAIT_WORD**:
  - `key`=1 → PRESS with `cnt`=0.
  - Otherwise `cnt` increments on `tick`. When it reaches WORD_GAP: `letter`=26, strobe `ex`, go to IDLE.
- A space is only ever emitted after a letter, so there are never two consecutive spaces.
- ERROR (31) is emitted when overflow is set or when the (len, pattern) pair is not a letter. The invalid 4-element patterns are ..--, .-.-, ---., ----.
- Lookup is the standard ITU A–Z table.

## Timing

- Reset values: `letter`=26, `ex`=0, state=IDLE, `cnt`=0, len=0, overflow=0. `ex` drops asynchronously when `reset` asserts.
- Latency: `ex` rises in the cycle after the `tick` cycle whose increment reached LETTER_GAP or WORD_GAP.
- `ex` is never high for two consecutive cycles.
- With `tick`=0, no counting occurs. A press with no intervening ticks classifies as a dot.
- Reset mid-press or mid-gap discards partial elements and emits no strobe.

## Structure

- Package `morse_pkg` holds:
  - the state enum;
  - constants CODE_SPACE=26 and CODE_ERR=31;
  - the code width of 5.
- Sub-module `morse_lut` is a combinational lookup: (len[2:0], pattern[3:0], overflow) → code[4:0].
- The FSM, counter and output registers stay in `morse_decoder`.

## Test plan

All scenarios use default parameters and `tick`=1 every cycle.

- Press for 1 tick, release for 3 ticks → single `ex` pulse with `letter`=4 (E). Continued release until 7 ticks after release → `ex` pulse with `letter`=26.
- Dot, 1-tick gap, dash held 3 ticks, release → `letter`=0 (A). Separately, ..-. → 5 (F); --.. → 25 (Z).
- Five dots separated by 1-tick gaps → `letter`=31; the next letter E decodes as 4.
- Pattern ---- → 31. Re-press at exactly gap tick 3 → no strobe, and the elements are merged into one letter.
- `tick` held 0 while `key` is pressed for 20 cycles, then ticking resumes → dot (E=4). With `tick`=0 throughout the gap, no `ex` is ever produced.
- Assert `reset` in the middle of a dash → `ex`=0 and `letter`=26 immediately. After release, T (dash) decodes as 19 with no stale elements.
